dds_tone_detector: RTL and testbench
====================================

DDS_TONE_DETECTOR -- requirements
Module: dds_tone_detector

Interface
REQ-001 SHALL have parameter MID, default 128: midscale crossing level for 8-bit unsigned samples.
REQ-002 SHALL have parameter HYST, default 8: hysteresis half-width in LSBs.
REQ-003 SHALL have parameters P0, P1, P2, P3, defaults 256, 128, 64, 32: nominal periods in samples for codes 00, 01, 10 and 11.
REQ-004 SHALL have parameter TOL, default 2: allowed absolute period error in samples for a code match.
REQ-005 SHALL have parameter LOCK_N, default 2: number of consecutive same-code matches required for lock.
REQ-006 clk  input  1: single clock; all state updates on the rising edge.
REQ-007 rst  input  1: reset, asynchronous, active-low.
REQ-008 sample_in  input  8: unsigned waveform sample from the DDS output.
REQ-009 sample_valid  input  1: sample_in is accepted on a clock edge only when this input is 1.
REQ-010 period  output  16: last measured period, in accepted samples.
REQ-011 period_valid  output  1: one-clock pulse when period is updated.
REQ-012 phase_code  output  2: decoded phase-control code of the last matching period.
REQ-013 locked  output  1: LOCK_N consecutive periods have matched the same code.
REQ-014 overflow  output  1: sticky flag; the period counter saturated.

Function
REQ-015 SHALL be a crossing FSM with states SEEK_LOW, SEEK_HIGH, and a flag armed.
- SEEK_LOW -> SEEK_HIGH on an accepted sample <= MID-HYST.
- SEEK_HIGH -> SEEK_LOW on an accepted sample >= MID+HYST; this transition is a rising event.
REQ-016 SHALL leave FSM state and counters unchanged on clocks with sample_valid=0.
REQ-017 SHALL hold 16-bit counter cnt; on each accepted non-rising sample, cnt <= cnt+1, saturating at 16'hFFFF.
REQ-018 SHALL treat the first rising event with armed=0 as follows: set armed=1, cnt <= 0, no period_valid pulse.
REQ-019 SHALL treat a rising event with armed=1 as follows: period <= cnt+1, period_valid=1 on the following cycle, cnt <= 0.
REQ-020 SHALL, when cnt reaches 16'hFFFF with armed=1: set overflow=1, clear armed and locked, and clear the match streak.
REQ-021 SHALL decode each new period to code k when |period - Pk| <= TOL, choosing the lowest k if several match; otherwise the period is a mismatch.
REQ-022 SHALL, on a match, update phase_code <= k in the same cycle as period_valid.
REQ-023 SHALL keep a 3-bit streak counter and update it per new period:
- same code as the previous match: streak increments, saturating;
- different code: streak becomes 1;
- mismatch: streak becomes 0 and phase_code is held.
REQ-024 SHALL set locked=1 while streak >= LOCK_N and clear it immediately on a mismatch or code change.
REQ-025 SHALL have decode and lock latency of one clock after the accepted rising sample: period, period_valid, phase_code and locked all update together.
REQ-026 SHALL set no flags on samples inside the hysteresis band (MID-HYST, MID+HYST); they only increment cnt.

Reset
REQ-027 SHALL, while rst=0, asynchronously force: state=SEEK_LOW, armed=0, cnt=0, streak=0, period=0, period_valid=0, phase_code=0, locked=0, overflow=0.
REQ-028 SHALL clear overflow only by reset.
REQ-029 SHALL, on reset asserted mid-measurement, discard the partial count; the first rising event after release only re-arms (REQ-018).

Verification
REQ-030 Square wave, sample_valid=1 every clock, 16 samples of 200 then 16 samples of 50, repeated -> from the second rising event onward, period=32, phase_code=11, period_valid pulses every 32 clocks, locked=1 at the second measured period.
REQ-031 Same stimulus at 64/64 (period 128) switched to 128/128 (period 256) -> first 256 period: phase_code=00, locked=0; locked=1 at the next period.
REQ-032 Period 100 square wave -> period_valid pulses with period=100, no phase_code change, locked=0.
REQ-033 Samples alternating 125/131 (inside band) for 70000 accepted samples after arming -> overflow=1, locked=0, no period_valid.
REQ-034 sample_valid low on every other clock, 32-sample square wave -> period=32 (counts accepted samples, not clocks).
REQ-035 rst pulsed low 10 samples after a rising event while locked=1 -> all outputs 0 immediately; first post-reset rising event produces no period_valid.

Source files
------------

// File: rtl/dds_tone_detector.sv
// Measures the period of a DDS waveform between hysteresis-qualified rising
// crossings, decodes it to a 2-bit phase-control code and tracks lock.
module dds_tone_detector #(
  parameter int MID    = 128,
  parameter int HYST   = 8,
  parameter int P0     = 256,
  parameter int P1     = 128,
  parameter int P2     = 64,
  parameter int P3     = 32,
  parameter int TOL    = 2,
  parameter int LOCK_N = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sample_in,
  input  logic        sample_valid,
  output logic [15:0] period,
  output logic        period_valid,
  output logic [1:0]  phase_code,
  output logic        locked,
  output logic        overflow,
  output logic        state_dbg
);

  // Handshake: sample_in is consumed on a rising edge where sample_valid=1;
  // there is no ready, so every valid sample is accepted.
  typedef enum logic {SEEK_LOW = 1'b0, SEEK_HIGH = 1'b1} state_t;

  localparam logic [7:0]  LO_TH   = 8'(MID - HYST);
  localparam logic [7:0]  HI_TH   = 8'(MID + HYST);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t      state, state_next;
  logic        rise;
  logic        armed;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic [2:0]  streak, streak_next;
  logic        dec_hit;
  logic [1:0]  dec_code;
  logic        lock_next;

  function automatic logic in_tol(input logic [15:0] p, input int nom);
    int d;
    d = int'({16'd0, p}) - nom;
    return (d <= TOL) && (d >= -TOL);
  endfunction

  assign cnt_inc   = cnt + 16'd1;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEEK_LOW;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    rise       = 1'b0;
    if (sample_valid) begin
      case (state)
        SEEK_LOW:  if (sample_in <= LO_TH) state_next = SEEK_HIGH;
        SEEK_HIGH: if (sample_in >= HI_TH) begin
          state_next = SEEK_LOW;
          rise       = 1'b1;
        end
        default:   state_next = SEEK_LOW;
      endcase
    end
  end

  // The candidate period is cnt+1: the rising sample itself closes the period.
  always_comb begin
    dec_hit  = 1'b1;
    dec_code = 2'd0;
    if      (in_tol(cnt_inc, P0)) dec_code = 2'd0;
    else if (in_tol(cnt_inc, P1)) dec_code = 2'd1;
    else if (in_tol(cnt_inc, P2)) dec_code = 2'd2;
    else if (in_tol(cnt_inc, P3)) dec_code = 2'd3;
    else                          dec_hit  = 1'b0;
  end

  always_comb begin
    streak_next = 3'd0;
    if (dec_hit) begin
      if (dec_code == phase_code) streak_next = (streak == 3'd7) ? streak : streak + 3'd1;
      else                        streak_next = 3'd1;
    end
    lock_next = (int'({29'd0, streak_next}) >= LOCK_N);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed        <= 1'b0;
      cnt          <= 16'd0;
      streak       <= 3'd0;
      period       <= 16'd0;
      period_valid <= 1'b0;
      phase_code   <= 2'd0;
      locked       <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (rise) begin
        cnt   <= 16'd0;
        armed <= 1'b1;
        if (armed) begin
          period       <= cnt_inc;
          period_valid <= 1'b1;
          streak       <= streak_next;
          locked       <= lock_next;
          if (dec_hit) phase_code <= dec_code;
        end
      end else if (sample_valid) begin
        if (cnt != CNT_MAX) cnt <= cnt_inc;
        // Armed cnt never rests at CNT_MAX, so cnt_inc cannot wrap here.
        if (armed && cnt_inc == CNT_MAX) begin
          overflow <= 1'b1;
          armed    <= 1'b0;
          locked   <= 1'b0;
          streak   <= 3'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_tone_detector.sv
// Directed-plus-random bench for dds_tone_detector; a sample-index based
// reference model predicts every output on every clock.
module tb_dds_tone_detector;

  localparam int MID    = 128;
  localparam int HYST   = 8;
  localparam int TOL    = 2;
  localparam int LOCK_N = 2;
  localparam int NOM [4] = '{256, 128, 64, 32};

  // clock / reset
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sample_in;
  logic        sample_valid;
  logic [15:0] period;
  logic        period_valid;
  logic [1:0]  phase_code;
  logic        locked;
  logic        overflow;
  logic        state_dbg;

  always #5 clk = ~clk;

  dds_tone_detector dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .period       (period),
    .period_valid (period_valid),
    .phase_code   (phase_code),
    .locked       (locked),
    .overflow     (overflow),
    .state_dbg    (state_dbg)
  );

  // reference model: rising events are located by accepted-sample index
  bit          m_seek_high;
  bit          m_armed;
  int          m_idx;
  int          m_rise_idx;
  logic [15:0] m_period;
  logic        m_pv;
  logic [1:0]  m_code;
  logic        m_locked;
  logic        m_ovf;
  int          m_hist[$];
  logic [15:0] exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  function automatic int decode(input int p);
    for (int k = 0; k < 4; k++)
      if (p >= NOM[k] - TOL && p <= NOM[k] + TOL) return k;
    return -1;
  endfunction

  function automatic logic hist_locked();
    int n;
    n = m_hist.size();
    if (n < LOCK_N) return 1'b0;
    for (int i = n - LOCK_N; i < n; i++)
      if (m_hist[i] < 0 || m_hist[i] != m_hist[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_seek_high = 0; m_armed = 0; m_idx = 0; m_rise_idx = 0;
    m_period = '0; m_pv = 0; m_code = '0; m_locked = 0; m_ovf = 0;
    m_hist.delete();
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [7:0] s);
    bit is_rise;
    int p;
    int code;
    is_rise = 0;
    m_pv = 0;
    if (!m_seek_high) begin
      if (int'(s) <= MID - HYST) m_seek_high = 1;
    end else if (int'(s) >= MID + HYST) begin
      m_seek_high = 0;
      is_rise = 1;
    end
    m_idx++;
    if (is_rise) begin
      if (m_armed) begin
        p = m_idx - m_rise_idx;
        m_period = 16'(p);
        m_pv = 1;
        exp_q.push_back(16'(p));
        code = decode(p);
        m_hist.push_back(code);
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        if (code >= 0) m_code = 2'(code);
      end
      m_armed = 1;
      m_rise_idx = m_idx;
    end else if (m_armed && (m_idx - m_rise_idx) == 65535) begin
      m_ovf = 1;
      m_armed = 0;
      m_hist.delete();
    end
    m_locked = hist_locked();
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("period_valid", 16'(period_valid), 16'(m_pv));
    chk("period", period, m_period);
    chk("phase_code", 16'(phase_code), 16'(m_code));
    chk("locked", 16'(locked), 16'(m_locked));
    chk("overflow", 16'(overflow), 16'(m_ovf));
    if (period_valid) begin
      if (exp_q.size() == 0) chk("period_q_empty", 16'(period_valid), 16'd0);
      else                   chk("period_q", period, exp_q.pop_front());
    end
  endtask

  // drivers: called at a falling edge, return at the next falling edge
  task automatic apply(input logic [7:0] s, input logic v);
    sample_in = s;
    sample_valid = v;
    @(posedge clk);
    if (v) model_accept(s);
    else   m_pv = 0;
    @(negedge clk);
    check_outputs();
  endtask

  // gap_mode: 0 none, 1 random idle clocks, 2 one idle clock per sample
  task automatic send(input logic [7:0] s, input int gap_mode);
    if (gap_mode == 2) apply(8'($urandom), 1'b0);
    else if (gap_mode == 1)
      while ($urandom_range(0, 3) == 0) apply(8'($urandom), 1'b0);
    apply(s, 1'b1);
  endtask

  function automatic logic [7:0] hi_val();
    return 8'($urandom_range(255, MID + HYST));
  endfunction

  function automatic logic [7:0] lo_val();
    return 8'($urandom_range(MID - HYST, 0));
  endfunction

  task automatic square(input int hi_len, input int lo_len, input int reps, input int gap_mode);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi_len; i++) send(hi_val(), gap_mode);
      for (int i = 0; i < lo_len; i++) send(lo_val(), gap_mode);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sample_valid = 1'b0;
    #1;
    chk("rst_period", period, 16'd0);
    chk("rst_period_valid", 16'(period_valid), 16'd0);
    chk("rst_phase_code", 16'(phase_code), 16'd0);
    chk("rst_locked", 16'(locked), 16'd0);
    chk("rst_overflow", 16'(overflow), 16'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int nom_k, off, n_per;
    sample_in = '0;
    sample_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // 32-sample square wave: code 11, locks at second measured period
    square(16, 16, 6, 0);
    chk("p32_period", period, 16'd32);
    chk("p32_code", 16'(phase_code), 16'd3);
    chk("p32_locked", 16'(locked), 16'd1);

    // 128 -> 256 period switch: first 256 decodes to 00 unlocked, next locks
    square(64, 64, 4, 0);
    square(128, 128, 2, 0);
    chk("p256_period", period, 16'd256);
    chk("p256_code", 16'(phase_code), 16'd0);
    chk("p256_first_locked", 16'(locked), 16'd0);
    send(hi_val(), 0);
    chk("p256_second_locked", 16'(locked), 16'd1);

    // period 100 matches nothing: code held, lock dropped
    square(50, 50, 4, 0);
    chk("p100_period", period, 16'd100);
    chk("p100_code", 16'(phase_code), 16'd0);
    chk("p100_locked", 16'(locked), 16'd0);

    // idle clock between every sample: period counts accepted samples only
    do_reset();
    square(16, 16, 4, 2);
    chk("gap_period", period, 16'd32);
    chk("gap_code", 16'(phase_code), 16'd3);

    // random periods around each nominal, including tolerance edges
    for (int seg = 0; seg < 10; seg++) begin
      nom_k = $urandom_range(0, 3);
      off = $urandom_range(0, 2 * TOL + 4) - (TOL + 2);
      n_per = NOM[nom_k] + off;
      square(n_per / 2, n_per - n_per / 2, $urandom_range(1, 3), 1);
    end
    square(16, 16, 1, 0);
    square(17, 17, 2, 0);
    chk("tol_edge_34", period, 16'd34);
    square(15, 14, 2, 0);
    chk("tol_edge_29_locked", 16'(locked), 16'd0);

    // reset while locked, ten samples after a rising event
    do_reset();
    square(16, 16, 5, 0);
    for (int i = 0; i < 11; i++) send(hi_val(), 0);
    chk("pre_rst_locked", 16'(locked), 16'd1);
    do_reset();
    square(16, 16, 3, 0);

    // in-band samples after arming saturate the counter
    do_reset();
    send(8'd50, 0);
    send(8'd200, 0);
    for (int i = 0; i < 70000; i++) send((i % 2) ? 8'd131 : 8'd125, 0);
    chk("ovf_flag", 16'(overflow), 16'd1);
    chk("ovf_locked", 16'(locked), 16'd0);
    square(16, 16, 3, 0);
    chk("ovf_sticky", 16'(overflow), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
